imm_gen_pipe: RTL and testbench

IMM_GEN_PIPE -- requirements
Module: imm_gen_pipe

---
 rtl/imm_gen_pipe.sv | 110 +++++++++++
 tb/tb_imm_gen_pipe.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: single-stage immediate generator with a valid/ready output
// register and an optional prefix register that widens the M and LDI formats.
module imm_gen_pipe #(
   parameter int DATA_W     = 64,
   parameter bit EXT_PREFIX = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [24:0]       imm_src,
   input  logic [2:0]        imm_sel,
   input  logic [DATA_W-1:0] i_regs,
   input  logic              flush,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] imm_out,
   output logic              pfx_pending,
   output logic              pfx_err
);

   localparam logic [2:0] IMM_M    = 3'b000;
   localparam logic [2:0] IMM_BR   = 3'b001;
   localparam logic [2:0] IMM_LDI  = 3'b010;
   localparam logic [2:0] IMM_LDUI = 3'b011;
   localparam logic [2:0] IMM_PFX  = 3'b100;

   logic              valid_reg;
   logic [DATA_W-1:0] imm_reg;
   logic [24:0]       prefix_reg;
   logic              pend_reg;
   logic              err_reg;

   logic              accept;
   logic              is_pfx;
   logic              widens;
   logic              err_next;
   logic [DATA_W-1:0] imm_next;

   // Only the low 17 bits of the register operand feed the LDUI format.
   logic              unused_bits;
   assign unused_bits = ^i_regs[DATA_W-1:17];

   // Ready depends only on the output register, never on flush.
   assign in_ready = !valid_reg || out_ready;
   assign accept   = in_valid && in_ready && !flush;

   // With the prefix mode disabled the PFX code is just another unlisted code.
   assign is_pfx = EXT_PREFIX && (imm_sel == IMM_PFX);

   // M and LDI are the only formats that legitimately consume a prefix.
   assign widens   = (imm_sel == IMM_M) || (imm_sel == IMM_LDI);
   assign err_next = accept && pend_reg && (is_pfx || !widens);

   // Format decode; the prefix only participates when one is pending.
   always_comb begin
      imm_next = '0;
      case (imm_sel)
         IMM_M: begin
            if (pend_reg)
               imm_next = {{(DATA_W-35){prefix_reg[24]}}, prefix_reg, imm_src[9:0]};
            else
               imm_next = {{(DATA_W-10){imm_src[9]}}, imm_src[9:0]};
         end
         IMM_LDI: begin
            if (pend_reg)
               imm_next = {{(DATA_W-45){prefix_reg[24]}}, prefix_reg, imm_src[19:0]};
            else
               imm_next = {{(DATA_W-20){imm_src[19]}}, imm_src[19:0]};
         end
         IMM_LDUI: imm_next = {{(DATA_W-32){1'b0}}, imm_src[14:0], i_regs[16:0]};
         IMM_BR:   imm_next = {{(DATA_W-17){1'b0}}, imm_src[16], 4'b0000, imm_src[15:4]};
         default:  imm_next = '0;
      endcase
   end

   // Output register, prefix storage and misuse pulse; flush drops everything.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_reg  <= 1'b0;
         imm_reg    <= '0;
         prefix_reg <= '0;
         pend_reg   <= 1'b0;
         err_reg    <= 1'b0;
      end else if (flush) begin
         valid_reg <= 1'b0;
         pend_reg  <= 1'b0;
         err_reg   <= 1'b0;
      end else begin
         err_reg <= err_next;
         if (accept && !is_pfx) begin
            valid_reg <= 1'b1;
            imm_reg   <= imm_next;
            pend_reg  <= 1'b0;
         end else if (out_ready) begin
            valid_reg <= 1'b0;
         end
         if (accept && is_pfx) begin
            prefix_reg <= imm_src;
            pend_reg   <= 1'b1;
         end
      end
   end

   assign out_valid   = valid_reg;
   assign imm_out     = imm_reg;
   assign pfx_pending = EXT_PREFIX && pend_reg;
   assign pfx_err     = EXT_PREFIX && err_reg;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Scoreboard bench for imm_gen_pipe: stimulus pushes expected immediates,
// a negedge monitor pops them on every output handshake.
module tb_imm_gen_pipe;

   localparam logic [2:0] S_M    = 3'b000;
   localparam logic [2:0] S_BR   = 3'b001;
   localparam logic [2:0] S_LDI  = 3'b010;
   localparam logic [2:0] S_LDUI = 3'b011;
   localparam logic [2:0] S_PFX  = 3'b100;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [24:0] imm_src = '0;
   logic [2:0]  imm_sel = '0;
   logic [63:0] i_regs = '0;
   logic        flush = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [63:0] imm_out;
   logic        pfx_pending;
   logic        pfx_err;

   int n_cmp = 0;
   int n_err = 0;
   int n_out = 0;

   // reference state
   logic [63:0] exp_q[$];
   bit          m_valid = 0;
   bit          m_pend = 0;
   bit          m_err = 0;
   logic [24:0] m_pfx = '0;

   imm_gen_pipe #(.DATA_W(64), .EXT_PREFIX(1'b1)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .imm_src(imm_src), .imm_sel(imm_sel), .i_regs(i_regs), .flush(flush),
      .out_valid(out_valid), .out_ready(out_ready), .imm_out(imm_out),
      .pfx_pending(pfx_pending), .pfx_err(pfx_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Immediate value computed arithmetically from the format rules.
   function automatic logic [63:0] ref_imm(input logic [2:0] sel, input logic [24:0] src,
                                           input logic [63:0] regs, input bit pend,
                                           input logic [24:0] pfx);
      longint v;
      int     w;
      v = 0;
      w = 0;
      case (sel)
         S_M: begin
            if (pend) begin v = longint'(pfx) * 1024 + longint'(src % 1024); w = 35; end
            else      begin v = longint'(src % 1024); w = 10; end
         end
         S_LDI: begin
            if (pend) begin v = longint'(pfx) * 1048576 + longint'(src % 1048576); w = 45; end
            else      begin v = longint'(src % 1048576); w = 20; end
         end
         S_LDUI: v = longint'(src % 32768) * 131072 + longint'(regs % 131072);
         S_BR:   v = longint'((src / 65536) % 2) * 65536 + longint'((src / 16) % 4096);
         default: v = 0;
      endcase
      if (w != 0 && v >= (longint'(1) << (w - 1)))
         v = v - (longint'(1) << w);
      return 64'(v);
   endfunction

   // Monitor: every handshake must match the oldest expected result.
   always @(negedge clk) begin
      if (!rst && out_valid && out_ready && !flush) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_output", imm_out, 64'hx);
         end else begin
            logic [63:0] e;
            e = exp_q.pop_front();
            n_out++;
            $display("out %0d: imm_out=%h expected=%h", n_out, imm_out, e);
            chk("imm_out", imm_out, e);
         end
      end
   end

   // One clock of stimulus; entered and left at posedge+1.
   task automatic step(input bit iv, input logic [2:0] sel, input logic [24:0] src,
                       input logic [63:0] regs, input bit fl, input bit ordy);
      bit acc;
      bit pfx_sel;
      in_valid = iv; imm_sel = sel; imm_src = src; i_regs = regs;
      flush = fl; out_ready = ordy;
      @(negedge clk);
      chk("in_ready", 64'(in_ready), 64'(!m_valid || ordy));
      @(posedge clk);
      acc = iv && (!m_valid || ordy) && !fl;
      pfx_sel = (sel == S_PFX);
      if (fl) begin
         m_valid = 0; m_pend = 0; m_err = 0;
         exp_q.delete();
      end else begin
         m_err = acc && m_pend && !(sel == S_M || sel == S_LDI);
         if (m_valid && ordy) m_valid = 0;
         if (acc) begin
            if (pfx_sel) begin
               m_pfx = src; m_pend = 1;
            end else begin
               exp_q.push_back(ref_imm(sel, src, regs, m_pend, m_pfx));
               m_valid = 1; m_pend = 0;
            end
         end
      end
      #1;
      chk("out_valid", 64'(out_valid), 64'(m_valid));
      chk("pfx_pending", 64'(pfx_pending), 64'(m_pend));
      chk("pfx_err", 64'(pfx_err), 64'(m_err));
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
      chk({tag, "_imm_out"}, imm_out, 64'd0);
      chk({tag, "_pfx_pending"}, 64'(pfx_pending), 64'd0);
      chk({tag, "_pfx_err"}, 64'(pfx_err), 64'd0);
      chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
   endtask

   task automatic do_reset(input string tag);
      rst = 1'b1; in_valid = 0; flush = 0; out_ready = 0;
      #1;
      check_reset_outputs(tag);
      m_valid = 0; m_pend = 0; m_err = 0; m_pfx = '0;
      exp_q.delete();
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) step(0, S_M, '0, '0, 0, 1);
   endtask

   initial begin
      do_reset("por");

      // all-ones M field sign-extends to all ones
      step(1, S_M, 25'h00003FF, '0, 0, 1);
      idle(1);

      // prefix then LDI forms a 45-bit value
      step(1, S_PFX, 25'h0000001, '0, 0, 1);
      step(1, S_LDI, 25'h0000005, '0, 0, 1);
      idle(1);

      // LDUI combines source and register bits
      step(1, S_LDUI, 25'h0007FFF, 64'h1_2345, 0, 1);
      idle(1);

      // stall for three cycles with a request waiting, then back-to-back
      step(1, S_LDI, 25'h0080001, '0, 0, 0);
      for (int k = 0; k < 3; k++) step(1, S_BR, 25'h1ABCDE0, '0, 0, 0);
      step(1, S_BR, 25'h1ABCDE0, '0, 0, 1);
      idle(1);

      // double prefix, then BR with a prefix pending
      step(1, S_PFX, 25'h1555555, '0, 0, 1);
      step(1, S_PFX, 25'h0AAAAAA, '0, 0, 1);
      step(1, S_BR, 25'h001FFF0, '0, 0, 1);
      idle(1);

      // flush with a pending prefix and a request offered
      step(1, S_PFX, 25'h1FFFFFF, '0, 0, 1);
      step(1, S_M, 25'h0000123, '0, 1, 1);
      // flush with a held output
      step(1, S_M, 25'h0000200, '0, 0, 0);
      step(0, S_M, '0, '0, 1, 1);
      // unlisted code yields zero
      step(1, 3'b110, 25'h1FFFFFF, '0, 0, 1);
      idle(1);

      // async reset mid-stall with a prefix stored, then no-prefix LDI
      step(1, S_PFX, 25'h0000007, '0, 0, 1);
      step(1, S_M, 25'h0000155, '0, 0, 0);
      step(1, S_PFX, 25'h0000009, '0, 0, 0);
      #2;
      do_reset("mid");
      step(1, S_LDI, 25'h00FFFFF, '0, 0, 1);
      idle(1);

      // randomized traffic
      for (int k = 0; k < 600; k++) begin
         int unsigned r;
         logic [2:0] s;
         r = $urandom_range(0, 11);
         if (r < 3)       s = S_M;
         else if (r < 6)  s = S_LDI;
         else if (r == 6) s = S_BR;
         else if (r == 7) s = S_LDUI;
         else if (r < 11) s = S_PFX;
         else             s = 3'($urandom_range(5, 7));
         step(($urandom % 4) != 0, s, 25'($urandom), {$urandom, $urandom},
              ($urandom % 30) == 0, ($urandom % 4) != 0);
      end
      idle(3);
      chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
